// File: rtl/tdm_pkg.sv
// Shared definitions for the 4:1 TDM link (TX mux and RX demux).
// Lane count, slot counter width and the receive framing states.
package tdm_pkg;

  localparam int TDM_LANES  = 4;
  localparam int TDM_SLOT_W = 2;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_e;

  typedef logic [TDM_SLOT_W-1:0] tdm_slot_t;

  localparam tdm_slot_t TDM_SLOT_FIRST = tdm_slot_t'(0);
  localparam tdm_slot_t TDM_SLOT_LAST  = tdm_slot_t'(TDM_LANES - 1);

endpackage

// File: rtl/tdm_slot_counter.sv
// Slot position within a TDM frame.
// clr has priority over load-to-1, which has priority over increment.
module tdm_slot_counter
  import tdm_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load1,
  input  logic      clr,
  input  logic      inc,
  output tdm_slot_t slot,
  output logic      is_last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= TDM_SLOT_FIRST;
    end else if (clr) begin
      slot <= TDM_SLOT_FIRST;
    end else if (load1) begin
      slot <= tdm_slot_t'(1);
    end else if (inc) begin
      slot <= slot + tdm_slot_t'(1);
    end
  end

  assign is_last = (slot == TDM_SLOT_LAST);

endmodule

// File: rtl/tdm_demux_1to4.sv
// Receive side of the 4:1 TDM link: aligns on in_sync, collects
// four slots and presents them as one parallel frame with out_valid.
module tdm_demux_1to4
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sync,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic             out_valid,
  output logic             locked,
  output logic             sync_err
);

  tdm_state_e state;
  tdm_state_e state_nxt;
  tdm_slot_t  slot;
  logic       is_last;

  logic       cnt_load;
  logic       cnt_clr;
  logic       cnt_inc;
  logic [2:0] sh_we;
  logic       out_we;
  logic       err_set;

  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic [WIDTH-1:0] sh2;

  tdm_slot_counter u_slot (
    .clk     (clk),
    .rst     (rst),
    .load1   (cnt_load),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .slot    (slot),
    .is_last (is_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    sh_we     = 3'b000;
    out_we    = 1'b0;
    err_set   = 1'b0;
    unique case (state)
      HUNT: begin
        if (in_valid && in_sync) begin
          sh_we[0]  = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (in_valid) begin
          if (in_sync) begin
            // Any sync restarts the frame; mid-frame it also flags an error.
            sh_we[0] = 1'b1;
            cnt_load = 1'b1;
            err_set  = (slot != TDM_SLOT_FIRST);
          end else if (slot == TDM_SLOT_FIRST) begin
            err_set   = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = HUNT;
          end else if (is_last) begin
            out_we  = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            sh_we[1] = (slot == tdm_slot_t'(1));
            sh_we[2] = (slot == tdm_slot_t'(2));
            cnt_inc  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = HUNT;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0 <= '0;
      sh1 <= '0;
      sh2 <= '0;
    end else begin
      if (sh_we[0]) sh0 <= in_data;
      if (sh_we[1]) sh1 <= in_data;
      if (sh_we[2]) sh2 <= in_data;
    end
  end

  // Lane 3 comes straight from the link so all lanes update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out0 <= '0;
      out1 <= '0;
      out2 <= '0;
      out3 <= '0;
    end else if (out_we) begin
      out0 <= sh0;
      out1 <= sh1;
      out2 <= sh2;
      out3 <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      out_valid <= out_we;
      sync_err  <= err_set;
    end
  end

  assign locked = (state == LOCKED);

endmodule
